// File: rtl/sram_pkg.sv
// Shared definitions for the single-port SRAM bank: write-collision mode
// codes, the clear/active state encoding and the even-parity helper.
package sram_pkg;

    // Output behaviour of a write access
    localparam int WR_FIRST  = 0;
    localparam int RD_FIRST  = 1;
    localparam int NO_CHANGE = 2;

    // Bank sequencer states
    typedef enum logic {
        CLEAR  = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    // Widest word the parity helper covers; narrower words are zero-extended,
    // which leaves the parity unchanged.
    localparam int PAR_MAX_W = 1024;

    // Even parity bit: makes the total number of ones (data + bit) even
    function automatic logic even_parity(input logic [PAR_MAX_W-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-return register pipeline for sram_sp_bank. Carries rvalid, rdata and
// the parity-error flag together through RD_LAT (1 or 2) register stages.
// Data stages only load on a valid beat, so rdata holds between accesses.
module sram_rd_pipe #(
    parameter int WIDTH  = 64,
    parameter int RD_LAT = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             vld_in,
    input  logic [WIDTH-1:0] data_in,
    input  logic             perr_in,
    output logic             rvalid,
    output logic [WIDTH-1:0] rdata,
    output logic             par_err
);

    logic             vld_p1;
    logic             perr_p1;
    logic [WIDTH-1:0] data_p1;

    // Stage p1: first registered copy of the access result
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            perr_p1 <= 1'b0;
            data_p1 <= '0;
        end else begin
            vld_p1  <= vld_in;
            perr_p1 <= vld_in & perr_in;
            if (vld_in) begin
                data_p1 <= data_in;
            end
        end
    end

    generate
        if (RD_LAT == 2) begin : g_lat2
            logic             vld_p2;
            logic             perr_p2;
            logic [WIDTH-1:0] data_p2;

            // Stage p2: extra output register, everything delayed together
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vld_p2  <= 1'b0;
                    perr_p2 <= 1'b0;
                    data_p2 <= '0;
                end else begin
                    vld_p2  <= vld_p1;
                    perr_p2 <= perr_p1;
                    if (vld_p1) begin
                        data_p2 <= data_p1;
                    end
                end
            end

            assign rvalid  = vld_p2;
            assign rdata   = data_p2;
            assign par_err = perr_p2;
        end else begin : g_lat1
            assign rvalid  = vld_p1;
            assign rdata   = data_p1;
            assign par_err = perr_p1;
        end
    endgenerate

endmodule

// File: rtl/sram_sp_bank.sv
// Parametrised single-port synchronous SRAM bank for the Viterbi survivor
// memory. Includes a power-on clear sequencer, out-of-range address detection
// with a sticky flag and configurable write-collision output behaviour.
// Optional per-word even parity is enabled by defining SRAM_PARITY_EN.
module sram_sp_bank
    import sram_pkg::*;
#(
    parameter int WIDTH      = 64,
    parameter int DEPTH      = 21,
    parameter int ADDR_W     = 5,
    parameter int RD_LAT     = 1,
    parameter int WR_MODE    = 0,
    parameter int INIT_CLEAR = 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cs,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [WIDTH-1:0]  wdata,
    output logic [WIDTH-1:0]  rdata,
    output logic              rvalid,
    output logic              busy,
    output logic              addr_err,
    input  logic              err_clr,
    output logic              par_err,
    output logic              par_err_sticky
);

    localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            state;
    state_t            state_nx;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] cnt_nx;

    logic              acc;
    logic              in_range;
    logic [WIDTH-1:0]  old_word;
    logic              par_bad;

    logic              vld_p0;
    logic [WIDTH-1:0]  data_p0;
    logic              perr_p0;
    logic              oob_p0;
    logic              oob_evt;

    logic [WIDTH-1:0]  mem [DEPTH];

    // Sequencer state and clear counter; reset restarts the clear from word 0
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= (INIT_CLEAR != 0) ? CLEAR : ACTIVE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next state: walk every word once in CLEAR, then stay ACTIVE
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            CLEAR: begin
                if (cnt == LAST_ADDR) begin
                    state_nx = ACTIVE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + 1'b1;
                end
            end
            default: begin
                state_nx = ACTIVE;
            end
        endcase
    end

    assign busy     = (state == CLEAR);
    assign acc      = cs & ~busy;
    assign in_range = ({1'b0, addr} < DEPTH_X);
    assign old_word = in_range ? mem[addr] : '0;

`ifdef SRAM_PARITY_EN
    logic par_mem [DEPTH];

    // Word and parity storage: zero fill while clearing, else in-range writes
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt]     <= '0;
            par_mem[cnt] <= 1'b0;
        end else if (acc && we && in_range) begin
            mem[addr]     <= wdata;
            par_mem[addr] <= even_parity(PAR_MAX_W'(wdata));
        end
    end

    assign par_bad = in_range ?
                     (even_parity(PAR_MAX_W'(old_word)) != par_mem[addr]) : 1'b0;
`else
    // Word storage: zero fill while clearing, else in-range writes
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[cnt] <= '0;
        end else if (acc && we && in_range) begin
            mem[addr] <= wdata;
        end
    end

    assign par_bad = 1'b0;
`endif

    // Stage p0: decode the access into the value to return and its flags
    always_comb begin
        vld_p0  = 1'b0;
        data_p0 = old_word;
        perr_p0 = 1'b0;
        oob_p0  = 1'b0;
        if (acc) begin
            oob_p0 = ~in_range;
            if (we) begin
                case (WR_MODE)
                    WR_FIRST: begin
                        vld_p0  = 1'b1;
                        data_p0 = wdata;
                    end
                    RD_FIRST: begin
                        vld_p0  = 1'b1;
                        perr_p0 = par_bad;
                    end
                    default: begin
                        vld_p0 = 1'b0;
                    end
                endcase
            end else begin
                vld_p0  = 1'b1;
                perr_p0 = par_bad;
            end
        end
    end

    sram_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk     (clk),
        .reset_n (reset_n),
        .vld_in  (vld_p0),
        .data_in (data_p0),
        .perr_in (perr_p0),
        .rvalid  (rvalid),
        .rdata   (rdata),
        .par_err (par_err)
    );

    // Out-of-range event follows the same latency as rvalid
    generate
        if (RD_LAT == 2) begin : g_oob_lat2
            logic oob_p1;

            // Stage p1: delay the out-of-range event by one cycle
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    oob_p1 <= 1'b0;
                end else begin
                    oob_p1 <= oob_p0;
                end
            end

            assign oob_evt = oob_p1;
        end else begin : g_oob_lat1
            assign oob_evt = oob_p0;
        end
    endgenerate

    // Sticky address error; a new error wins over err_clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_err <= 1'b0;
        end else if (oob_evt) begin
            addr_err <= 1'b1;
        end else if (err_clr) begin
            addr_err <= 1'b0;
        end
    end

`ifdef SRAM_PARITY_EN
    // Sticky parity error; a new mismatch wins over err_clr
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_err_sticky <= 1'b0;
        end else if (par_err) begin
            par_err_sticky <= 1'b1;
        end else if (err_clr) begin
            par_err_sticky <= 1'b0;
        end
    end
`else
    assign par_err_sticky = 1'b0;
`endif

endmodule

// File: tb/tb_sram_sp_bank.sv
// Testbench for sram_sp_bank: three instances (WRITE_FIRST/lat1,
// READ_FIRST/lat2, NO_CHANGE/lat1) share one stimulus stream and are checked
// every cycle against an array-based behavioural model.
module tb_sram_sp_bank;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cs;
    logic        we;
    logic        err_clr;
    logic [4:0]  addr;
    logic [63:0] wdata;

    logic [63:0] rdata [3];
    logic        rvalid [3];
    logic        busy [3];
    logic        addr_err [3];
    logic        par_err [3];
    logic        par_err_sticky [3];

    always #5 clk = ~clk;

    sram_sp_bank #(.WR_MODE(0), .RD_LAT(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[0]), .rvalid(rvalid[0]), .busy(busy[0]), .addr_err(addr_err[0]),
        .err_clr(err_clr), .par_err(par_err[0]), .par_err_sticky(par_err_sticky[0]));

    sram_sp_bank #(.WR_MODE(1), .RD_LAT(2)) dut1 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[1]), .rvalid(rvalid[1]), .busy(busy[1]), .addr_err(addr_err[1]),
        .err_clr(err_clr), .par_err(par_err[1]), .par_err_sticky(par_err_sticky[1]));

    sram_sp_bank #(.WR_MODE(2), .RD_LAT(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .cs(cs), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata[2]), .rvalid(rvalid[2]), .busy(busy[2]), .addr_err(addr_err[2]),
        .err_clr(err_clr), .par_err(par_err[2]), .par_err_sticky(par_err_sticky[2]));

    // Reference model state
    int          mode [3] = '{0, 1, 2};
    int          lat  [3] = '{1, 2, 1};
    logic [63:0] mdl_mem [21];
    logic        par_bad [21];
    int          clear_left;
    logic        exp_busy;
    logic [63:0] exp_rdata [3];
    logic        exp_rvalid [3];
    logic        exp_aerr [3];
    logic        exp_par [3];
    logic        exp_pstk [3];
    logic        dly_v [3];
    logic        dly_o [3];
    logic        dly_p [3];
    logic [63:0] dly_d [3];

    int n_vec = 0;
    int n_err = 0;

    function automatic logic [68:0] obs_of(input int k);
        return {busy[k], rvalid[k], addr_err[k], par_err[k], par_err_sticky[k], rdata[k]};
    endfunction

    function automatic logic [68:0] exp_of(input int k);
        return {exp_busy, exp_rvalid[k], exp_aerr[k], exp_par[k], exp_pstk[k], exp_rdata[k]};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 21; i++) begin
            mdl_mem[i] = '0;
            par_bad[i] = 1'b0;
        end
        clear_left = 21;
        exp_busy   = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_rdata[k]  = '0;
            exp_rvalid[k] = 1'b0;
            exp_aerr[k]   = 1'b0;
            exp_par[k]    = 1'b0;
            exp_pstk[k]   = 1'b0;
            dly_v[k]      = 1'b0;
            dly_o[k]      = 1'b0;
            dly_p[k]      = 1'b0;
            dly_d[k]      = '0;
        end
    endtask

    // Apply one sampled access to the model
    task automatic model_edge(input logic c, input logic w, input logic [4:0] a,
                              input logic [63:0] d, input logic ec);
        logic        act, oob, pb;
        logic [63:0] old;
        logic        ev_v, ev_o, ev_p, o_v, o_o, o_p;
        logic [63:0] ev_d, o_d;
        act = (clear_left == 0);
        oob = (a >= 5'd21);
        old = oob ? 64'd0 : mdl_mem[a];
        pb  = oob ? 1'b0 : par_bad[a];
        for (int k = 0; k < 3; k++) begin
            ev_v = 1'b0; ev_o = 1'b0; ev_p = 1'b0; ev_d = '0;
            if (act && c) begin
                ev_o = oob;
                if (!w) begin
                    ev_v = 1'b1; ev_d = old; ev_p = pb;
                end else if (mode[k] == 0) begin
                    ev_v = 1'b1; ev_d = d;
                end else if (mode[k] == 1) begin
                    ev_v = 1'b1; ev_d = old; ev_p = pb;
                end
            end
            if (lat[k] == 2) begin
                o_v = dly_v[k]; o_o = dly_o[k]; o_p = dly_p[k]; o_d = dly_d[k];
                dly_v[k] = ev_v; dly_o[k] = ev_o; dly_p[k] = ev_p; dly_d[k] = ev_d;
            end else begin
                o_v = ev_v; o_o = ev_o; o_p = ev_p; o_d = ev_d;
            end
            exp_rvalid[k] = o_v;
            if (o_v) exp_rdata[k] = o_d;
            exp_par[k] = o_p;
            if (o_o) exp_aerr[k] = 1'b1;
            else if (ec) exp_aerr[k] = 1'b0;
`ifdef SRAM_PARITY_EN
            if (o_p) exp_pstk[k] = 1'b1;
            else if (ec) exp_pstk[k] = 1'b0;
`endif
        end
        if (act && c && w && !oob) begin
            mdl_mem[a] = d;
            par_bad[a] = 1'b0;
        end
        if (clear_left > 0) clear_left--;
        exp_busy = (clear_left > 0);
    endtask

    // Drive one cycle of inputs, advance model at the edge, settle #1 after it
    task automatic step(input logic c, input logic w, input logic [4:0] a,
                        input logic [63:0] d, input logic ec);
        cs = c; we = w; addr = a; wdata = d; err_clr = ec;
        @(posedge clk);
        model_edge(c, w, a, d, ec);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        cs = 1'b0; we = 1'b0; addr = '0; wdata = '0; err_clr = 1'b0;
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (obs_of(k) !== exp_of(k)) begin
                n_err++;
                $display("FAIL reset dut%0d got %h want %h", k, obs_of(k), exp_of(k));
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_clear();
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom(), $urandom()}, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_of(k) !== exp_of(k)) begin
                    n_err++;
                    $display("FAIL clear_busy dut%0d cyc%0d got %h want %h", k, i, obs_of(k), exp_of(k));
                end
            end
        end
        for (int a = 0; a <= 22; a++) begin
            if (a <= 20) step(1'b1, 1'b0, 5'(a), '0, 1'b0);
            else         step(1'b0, 1'b0, 5'd0, '0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_of(k) !== exp_of(k)) begin
                    n_err++;
                    $display("FAIL clear_read dut%0d a%0d got %h want %h", k, a, obs_of(k), exp_of(k));
                end
            end
        end
    endtask

    task automatic test_write_modes();
        logic [63:0] pat;
        pat = 64'hDEADBEEF_01234567;
        step(1'b1, 1'b1, 5'd5, pat, 1'b0);
        n_vec++;
        if (rdata[0] !== pat || rvalid[0] !== 1'b1 || rvalid[2] !== 1'b0 || rdata[2] !== 64'd0) begin
            n_err++;
            $display("FAIL wr_first_wr got %h/%b nc %h/%b want %h/1 nc 0/0",
                     rdata[0], rvalid[0], rdata[2], rvalid[2], pat);
        end
        step(1'b1, 1'b0, 5'd5, '0, 1'b0);
        n_vec++;
        if (rdata[0] !== pat || rvalid[1] !== 1'b1 || rdata[1] !== 64'd0) begin
            n_err++;
            $display("FAIL rd_first_wr got %h rf %h/%b want %h rf 0/1",
                     rdata[0], rdata[1], rvalid[1], pat);
        end
        step(1'b0, 1'b0, 5'd0, '0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (obs_of(k) !== exp_of(k)) begin
                n_err++;
                $display("FAIL write_modes dut%0d got %h want %h", k, obs_of(k), exp_of(k));
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            if (i < 3) step(1'b1, 1'b1, 5'(4 + i), {$urandom(), $urandom()}, 1'b0);
            else       step(1'b1, 1'b0, 5'(1 + i), '0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 5'd0, '0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_of(k) !== exp_of(k)) begin
                    n_err++;
                    $display("FAIL b2b dut%0d cyc%0d got %h want %h", k, i, obs_of(k), exp_of(k));
                end
            end
        end
    endtask

    task automatic test_addr_err();
        logic [4:0]  a_seq [6] = '{5'd25, 5'd25, 5'd30, 5'd0, 5'd0, 5'd0};
        logic        c_seq [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        w_seq [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic        e_seq [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            step(c_seq[i], w_seq[i], a_seq[i], {$urandom(), $urandom()}, e_seq[i]);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_of(k) !== exp_of(k)) begin
                    n_err++;
                    $display("FAIL addr_err dut%0d cyc%0d got %h want %h", k, i, obs_of(k), exp_of(k));
                end
            end
            if (i == 1) begin
                n_vec++;
                if (rdata[0] !== 64'd0 || addr_err[0] !== 1'b1) begin
                    n_err++;
                    $display("FAIL oob_read got %h err %b want 0 err 1", rdata[0], addr_err[0]);
                end
            end
        end
        n_vec++;
        if (addr_err[0] !== 1'b0) begin
            n_err++;
            $display("FAIL err_clr got %b want 0", addr_err[0]);
        end
    endtask

    task automatic test_mid_clear_reset();
        int ncyc;
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #2;
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 5'(i), '0, 1'b0);
        reset_n = 1'b0;
        model_reset();
        #2;
        for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (obs_of(k) !== exp_of(k)) begin
                n_err++;
                $display("FAIL mid_reset dut%0d got %h want %h", k, obs_of(k), exp_of(k));
            end
        end
        @(negedge clk);
        reset_n = 1'b1;
        ncyc = 0;
        while (busy[0] === 1'b1 && ncyc < 40) begin
            ncyc++;
            step(1'b1, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                 {$urandom(), $urandom()}, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_of(k) !== exp_of(k)) begin
                    n_err++;
                    $display("FAIL reclear dut%0d cyc%0d got %h want %h", k, ncyc, obs_of(k), exp_of(k));
                end
            end
        end
        n_vec++;
        if (ncyc != 21) begin
            n_err++;
            $display("FAIL busy_len got %0d cycles want 21", ncyc);
        end
    endtask

    task automatic test_parity();
`ifdef SRAM_PARITY_EN
        dut0.mem[3] = dut0.mem[3] ^ 64'h1;
        dut1.mem[3] = dut1.mem[3] ^ 64'h1;
        dut2.mem[3] = dut2.mem[3] ^ 64'h1;
        mdl_mem[3]  = mdl_mem[3] ^ 64'h1;
        par_bad[3]  = 1'b1;
`endif
        for (int i = 0; i < 5; i++) begin
            if (i == 0) step(1'b1, 1'b0, 5'd3, '0, 1'b0);
            else if (i == 3) step(1'b0, 1'b0, 5'd0, '0, 1'b1);
            else step(1'b0, 1'b0, 5'd0, '0, 1'b0);
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_of(k) !== exp_of(k)) begin
                    n_err++;
                    $display("FAIL parity dut%0d cyc%0d got %h want %h", k, i, obs_of(k), exp_of(k));
                end
            end
        end
    endtask

    task automatic test_random();
        logic [4:0] a;
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(21, 31)) : 5'($urandom_range(0, 20));
            step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                 {$urandom(), $urandom()}, 1'($urandom_range(0, 9) == 0));
            for (int k = 0; k < 3; k++) begin
                n_vec++;
                if (obs_of(k) !== exp_of(k)) begin
                    n_err++;
                    $display("FAIL random dut%0d cyc%0d got %h want %h", k, i, obs_of(k), exp_of(k));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_write_modes();
        test_back_to_back();
        test_addr_err();
        test_mid_clear_reset();
        test_parity();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_sp_bank.md
Name: sram_sp_bank

Overview:
Parametrised, synthesizable single-port synchronous SRAM bank. It is the successor to the fixed 21x64 survivor-path bank used by the Viterbi SPMU.
- Adds configurable width, depth, read latency and write-collision mode.
- Adds a power-on clear sequencer, out-of-range address detection, and a deterministic hold output in place of high-Z.
- One instance per survivor-memory bank; clocked by the decoder's divided clock.

Parameters:
WIDTH, 64, data word width in bits
DEPTH, 21, number of words
ADDR_W, 5, address width; ceil(log2(DEPTH)) <= ADDR_W
RD_LAT, 1, read latency in cycles; legal values 1 or 2
WR_MODE, 0, output on write: 0 WRITE_FIRST, 1 READ_FIRST, 2 NO_CHANGE
INIT_CLEAR, 1, 1 = zero every word after reset before accepting accesses

Ports:
clk  in  1  bank clock, rising edge
reset_n  in  1  asynchronous active-low reset
cs  in  1  chip select; access only when high and busy low
we  in  1  write enable (qualified by cs)
addr  in  ADDR_W  word address
wdata  in  WIDTH  write data
rdata  out  WIDTH  registered read data
rvalid  out  1  one-cycle pulse aligned with new rdata
busy  out  1  high while the clear sequence runs
addr_err  out  1  sticky out-of-range flag
err_clr  in  1  clears addr_err and par_err_sticky
par_err  out  1  parity mismatch pulse (see Optional Feature)
par_err_sticky  out  1  sticky parity flag

Behaviour:
- Reset (async assert): rdata=0, rvalid=0, addr_err=0, par_err=0, par_err_sticky=0, clear counter=0. FSM goes to CLEAR if INIT_CLEAR=1, else ACTIVE. busy=1 in CLEAR.
- Memory contents are not reset asynchronously.
- FSM states:
  - CLEAR: each cycle writes 0 to mem[cnt] and increments cnt. After writing cnt=DEPTH-1, next state is ACTIVE and busy drops. Duration is exactly DEPTH cycles after reset deassert.
  - ACTIVE: normal operation; stays here until the next reset.
- While busy: cs/we/addr are ignored, rvalid stays 0, and no addr_err is raised.
- Reset asserted mid-clear restarts CLEAR from cnt=0.
- Access is sampled at a rising edge with cs=1 in ACTIVE:
  - Write (we=1): mem[addr] <= wdata.
    - WRITE_FIRST: rdata=wdata, rvalid=1.
    - READ_FIRST: rdata=old mem[addr], rvalid=1.
    - NO_CHANGE: rdata held, rvalid=0.
  - Read (we=0): rdata=mem[addr], rvalid=1.
- Latency: with RD_LAT=1, rdata/rvalid update at the first edge after sampling. With RD_LAT=2, one extra register stage; rdata/rvalid are delayed together by one more cycle.
- cs=0: no memory change, rvalid=0, rdata holds its last value.
- Out-of-range address (addr >= DEPTH), e.g. addr 21..31 at defaults:
  - Write is dropped; memory is unchanged.
  - Read returns rdata=0 with rvalid=1.
  - addr_err sets in the same cycle rvalid would assert and stays set until err_clr.
- err_clr coinciding with a new error: set wins; the flag stays 1.
- Back-to-back accesses every cycle are supported; throughput is 1 access per cycle.

Optional Feature:
SRAM_PARITY_EN
- Defined:
  - Each word stores an extra even-parity bit computed from wdata on write, or 0 during CLEAR.
  - On read, recomputed parity is compared with the stored bit. A mismatch pulses par_err aligned with rvalid and sets par_err_sticky (cleared by err_clr; set wins).
  - WRITE_FIRST writes never flag.
  - Out-of-range reads never flag.
- Undefined: no parity storage; par_err and par_err_sticky are tied 0.

Decomposition:
- Package sram_pkg holds:
  - WR_MODE constants WR_FIRST=0, RD_FIRST=1, NO_CHANGE=2.
  - FSM state encoding CLEAR/ACTIVE.
  - A parity function.
- Sub-module sram_rd_pipe: a parametrised (RD_LAT) register pipeline carrying {rvalid, rdata, par_err}. It is instantiated once inside sram_sp_bank.

Test Plan:
1. Reset release, INIT_CLEAR=1, DEPTH=21 -> busy high exactly 21 cycles. Then read addr 0..20 -> rdata=0 each, rvalid one cycle after each cs (RD_LAT=1).
2. Write 64'hDEADBEEF_01234567 to addr 5 with WR_MODE=0, then read addr 5 -> rdata=wdata on the write cycle+1 and again on the read cycle+1. With WR_MODE=1, the write returns the old value 0. With WR_MODE=2, the write gives rvalid=0 and rdata unchanged.
3. RD_LAT=2: read addr 5 -> rvalid/rdata appear 2 cycles after sampling. Back-to-back reads of 4,5,6 -> three consecutive rvalid pulses in order.
4. Write addr 25 then read addr 25 -> memory unchanged, rdata=0, addr_err=1. Pulse err_clr together with another read of addr 30 -> addr_err stays 1. Pulse err_clr alone -> addr_err=0.
5. Assert reset_n low at clear cycle 10, release -> busy high for a full 21 cycles; cs pulses during busy give rvalid=0.
6. With SRAM_PARITY_EN: force a bit flip in stored word 3, then read addr 3 -> par_err pulse with rvalid and par_err_sticky=1. Without the macro -> par_err stays 0.
